// File: rtl/mem_pkg.sv
// Shared memory-request definitions for the request FIFO and mem_shim.
// Command encodings, field widths and the stored request record.
package mem_pkg;

  localparam logic [1:0] CMD_NOOP  = 2'd0;
  localparam logic [1:0] CMD_RSVD  = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;
  localparam logic [1:0] CMD_WRITE = 2'd3;

  localparam int MEM_ADDR_W = 22;
  localparam int MEM_DATA_W = 64;

  typedef struct packed {
    logic [1:0]            cmd;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] dta;
  } mem_req_t;

endpackage

// File: rtl/mem_req_ram.sv
// Simple dual-port storage array for queued memory requests.
// Synchronous write, asynchronous read; contents are never reset.
module mem_req_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 88,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Store one record per accepted push.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_req_fifo.sv
// First-word-fall-through request queue in front of mem_shim.
// Drops NOOP pushes, flags almost-full and latches overflow.
module mem_req_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mem_req_wr_cmd,
  input  logic [MEM_ADDR_W-1:0]   mem_req_wr_addr,
  input  logic [MEM_DATA_W-1:0]   mem_req_wr_dta,
  input  logic                    mem_req_wr_en,
  output logic                    mem_req_wr_almost_full,
  output logic                    mem_req_wr_overflow,
  output logic [1:0]              mem_req_rd_cmd,
  output logic [MEM_ADDR_W-1:0]   mem_req_rd_addr,
  output logic [MEM_DATA_W-1:0]   mem_req_rd_dta,
  output logic                    mem_req_rd_valid,
  input  logic                    mem_req_rd_en,
  output logic [$clog2(DEPTH):0]  mem_req_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = $bits(mem_req_t);

  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(AF_MARGIN);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic          w_valid;
  logic          w_full;
  logic          w_push_req;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  mem_req_t      w_wr_rec;
  logic [RW-1:0] w_rd_raw;
  mem_req_t      w_head;

  assign w_valid    = (r_count != '0);
  assign w_full     = (r_count == FULL_LVL);
  assign w_push_req = mem_req_wr_en && (mem_req_wr_cmd != CMD_NOOP);
  assign w_pop      = mem_req_rd_en && w_valid;
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  assign w_wr_rec = '{cmd:  mem_req_wr_cmd,
                      addr: mem_req_wr_addr,
                      dta:  mem_req_wr_dta};

  mem_req_ram #(
    .DEPTH (DEPTH),
    .WIDTH (RW),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_rec),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_raw)
  );

  // Advance pointers and occupancy on accepted pushes and pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
    end
  end

  // Sticky record of any push lost to a full queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_ovf <= 1'b0;
    else if (w_drop) r_ovf <= 1'b1;
  end

  assign w_head = w_rd_raw & {RW{w_valid}};

  assign mem_req_rd_valid       = w_valid;
  assign mem_req_rd_cmd         = w_head.cmd;
  assign mem_req_rd_addr        = w_head.addr;
  assign mem_req_rd_dta         = w_head.dta;
  assign mem_req_wr_almost_full = (FULL_LVL - r_count) <= AF_LVL;
  assign mem_req_wr_overflow    = r_ovf;
  assign mem_req_level          = r_count;

endmodule

// File: tb/tb_mem_req_fifo.sv
// Self-checking bench for mem_req_fifo (DEPTH=16, AF_MARGIN=4).
// Random and directed traffic compared to a queue-based model.
module tb_mem_req_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  wr_cmd = '0;
  logic [21:0] wr_addr = '0;
  logic [63:0] wr_dta = '0;
  logic        wr_en = 1'b0;
  logic        af;
  logic        ovf;
  logic [1:0]  rd_cmd;
  logic [21:0] rd_addr;
  logic [63:0] rd_dta;
  logic        rd_valid;
  logic        rd_en = 1'b0;
  logic [4:0]  level;

  int checks = 0;
  int errors = 0;

  logic [87:0] q[$];
  logic        m_ovf = 1'b0;

  logic [95:0] dut_vec;
  assign dut_vec = {rd_valid, af, ovf, level, rd_cmd, rd_addr, rd_dta};

  always #5 clk = ~clk;

  mem_req_fifo #(
    .DEPTH     (16),
    .AF_MARGIN (4)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .mem_req_wr_cmd         (wr_cmd),
    .mem_req_wr_addr        (wr_addr),
    .mem_req_wr_dta         (wr_dta),
    .mem_req_wr_en          (wr_en),
    .mem_req_wr_almost_full (af),
    .mem_req_wr_overflow    (ovf),
    .mem_req_rd_cmd         (rd_cmd),
    .mem_req_rd_addr        (rd_addr),
    .mem_req_rd_dta         (rd_dta),
    .mem_req_rd_valid       (rd_valid),
    .mem_req_rd_en          (rd_en),
    .mem_req_level          (level)
  );

  function automatic logic [95:0] exp_vec();
    logic [87:0] h;
    int n;
    n = q.size();
    h = (n != 0) ? q[0] : 88'd0;
    return {n != 0, (16 - n) <= 4, m_ovf, 5'(n), h};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic step(input logic we, input logic [1:0] c,
                      input logic [21:0] a, input logic [63:0] d,
                      input logic re);
    logic full;
    logic pop;
    wr_en = we; wr_cmd = c; wr_addr = a; wr_dta = d; rd_en = re;
    @(posedge clk);
    if (!rst) begin
      full = (q.size() == 16);
      pop  = re && (q.size() != 0);
      if (pop) void'(q.pop_front());
      if (we && c != 2'd0) begin
        if (!full || pop) q.push_back({c, a, d});
        else m_ovf = 1'b1;
      end
    end
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 22'd0, 64'd0, 1'b0);
  endtask

  task automatic pop1();
    step(1'b0, 2'd0, 22'd0, 64'd0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_vec !== 96'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h exp 0", dut_vec);
    end
    rst = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    idle();
  endtask

  task automatic test_single();
    step(1'b1, 2'd2, 22'h1BCDEF, 64'h0123_4567_89AB_CDEF, 1'b0);
    checks++;
    if ({rd_valid, rd_cmd, rd_addr, level} !==
        {1'b1, 2'd2, 22'h1BCDEF, 5'd1}) begin
      errors++;
      $display("FAIL single_head: got v%b c%0d a%h l%0d exp v1 c2 a1bcdef l1",
               rd_valid, rd_cmd, rd_addr, level);
    end
    pop1();
    checks++;
    if (dut_vec !== 96'd0) begin
      errors++;
      $display("FAIL single_pop_empty: got %h exp 0", dut_vec);
    end
  endtask

  task automatic test_noop();
    step(1'b1, 2'd3, 22'h123456, 64'hDEADBEEFCAFEBABE, 1'b0);
    step(1'b1, 2'd0, 22'($urandom()), rnd64(), 1'b0);
    checks++;
    if ({level, ovf, rd_cmd, rd_addr, rd_dta} !==
        {5'd1, 1'b0, 2'd3, 22'h123456, 64'hDEADBEEFCAFEBABE}) begin
      errors++;
      $display("FAIL noop_discard: got l%0d o%b c%0d a%h d%h exp l1 o0 c3 a123456 ddeadbeefcafebabe",
               level, ovf, rd_cmd, rd_addr, rd_dta);
    end
    pop1();
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 2'($urandom_range(1, 3)), 22'($urandom()), rnd64(), 1'b0);
      checks++;
      if (af !== (i + 1 >= 12) || dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL fill_%0d: got af%b %h exp af%b %h",
                 i, af, dut_vec, (i + 1 >= 12), exp_vec());
      end
    end
    step(1'b1, 2'd3, 22'h3FFFFF, rnd64(), 1'b0);
    checks++;
    if ({ovf, level} !== {1'b1, 5'd16} || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL overflow: got o%b l%0d exp o1 l16", ovf, level);
    end
  endtask

  task automatic test_full_pushpop();
    logic [63:0] d;
    d = rnd64();
    step(1'b1, 2'd1, 22'h2AAAAA, d, 1'b1);
    checks++;
    if (level !== 5'd16 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL full_pushpop: got %h exp %h", dut_vec, exp_vec());
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL drain_%0d: got %h exp %h", i, dut_vec, exp_vec());
      end
      if (i == 15) begin
        checks++;
        if ({rd_cmd, rd_addr, rd_dta} !== {2'd1, 22'h2AAAAA, d}) begin
          errors++;
          $display("FAIL full_pushpop_last: got %h exp %h",
                   {rd_cmd, rd_addr, rd_dta}, {2'd1, 22'h2AAAAA, d});
        end
      end
      pop1();
    end
    checks++;
    if (rd_valid !== 1'b0 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL drain_empty: got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_empty_pushpop();
    logic [63:0] d;
    d = rnd64();
    step(1'b1, 2'd2, 22'h155555, d, 1'b1);
    checks++;
    if ({level, rd_cmd, rd_addr, rd_dta} !== {5'd1, 2'd2, 22'h155555, d}) begin
      errors++;
      $display("FAIL empty_pushpop: got l%0d %h exp l1 %h",
               level, {rd_cmd, rd_addr, rd_dta}, {2'd2, 22'h155555, d});
    end
    pop1();
  endtask

  task automatic test_hold();
    logic [95:0] snap;
    for (int i = 0; i < 3; i++)
      step(1'b1, 2'($urandom_range(2, 3)), 22'($urandom()), rnd64(), 1'b0);
    snap = exp_vec();
    for (int i = 0; i < 10; i++) begin
      idle();
      checks++;
      if (dut_vec !== snap) begin
        errors++;
        $display("FAIL hold_%0d: got %h exp %h", i, dut_vec, snap);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 2'($urandom_range(1, 3)), 22'($urandom()), rnd64(), 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL b2b_%0d: got %h exp %h", i, dut_vec, exp_vec());
      end
    end
    while (q.size() != 0) pop1();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 17; i++)
      step(1'b1, 2'd2, 22'($urandom()), rnd64(), 1'b0);
    for (int i = 0; i < 11; i++) pop1();
    checks++;
    if ({level, ovf} !== {5'd5, 1'b1} || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL pre_reset: got l%0d o%b exp l5 o1", level, ovf);
    end
    #3;
    rd_en = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if (dut_vec !== 96'd0) begin
      errors++;
      $display("FAIL async_reset: got %h exp 0", dut_vec);
    end
    @(posedge clk);
    #2;
    checks++;
    if (dut_vec !== 96'd0) begin
      errors++;
      $display("FAIL reset_hold: got %h exp 0", dut_vec);
    end
    rst = 1'b0;
    rd_en = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'd3, 22'($urandom()), rnd64(), i[0]);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL post_reset_%0d: got %h exp %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 2'($urandom()),
           22'($urandom()), rnd64(), ($urandom_range(0, 2) == 0));
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random_%0d: got %h exp %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_noop();
    test_fill_overflow();
    test_full_pushpop();
    test_empty_pushpop();
    test_hold();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_req_fifo.md
# mem_req_fifo

Request buffer directly upstream of `mem_shim`. It accepts memory commands (cmd, 22-bit word address, 64-bit data) from the MPEG2 core's memory-request port and stores them in a first-word-fall-through queue. It presents the head entry on the `mem_req_rd_*` port that `mem_shim` pops, and gives the core an almost-full back-pressure signal. NOOP commands are discarded on entry, and overflow is latched for debug.

## Interface
- `DEPTH`, default 16: number of entries; power of two, 4..256.
- `AF_MARGIN`, default 4: `mem_req_wr_almost_full` asserts when free slots ≤ `AF_MARGIN`; range 1..DEPTH-1.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `mem_req_wr_cmd` in 2: command; 0 NOOP, 1 reserved, 2 READ, 3 WRITE.
- `mem_req_wr_addr` in 22: 64-bit word address.
- `mem_req_wr_dta` in 64: write data; stored for all commands.
- `mem_req_wr_en` in 1: push strobe, one entry per cycle.
- `mem_req_wr_almost_full` out 1: back-pressure to the core.
- `mem_req_wr_overflow` out 1: sticky; a push was dropped because the queue was full.
- `mem_req_rd_cmd` out 2: head command; 0 when `mem_req_rd_valid`=0.
- `mem_req_rd_addr` out 22: head address; 0 when `mem_req_rd_valid`=0.
- `mem_req_rd_dta` out 64: head data; 0 when `mem_req_rd_valid`=0.
- `mem_req_rd_valid` out 1: head entry present.
- `mem_req_rd_en` in 1: pop strobe from `mem_shim`; ignored when `mem_req_rd_valid`=0.
- `mem_req_level` out $clog2(DEPTH)+1: current occupancy.

## Operation
- Storage: `DEPTH`-entry array of 88-bit records {cmd, addr, dta}. The array is not reset.
- Pointers: `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. `count` ranges 0..DEPTH.
- Push qualifies when `mem_req_wr_en`=1 and cmd≠0.
  - A cmd=0 push is silently discarded: no state change, no overflow.
  - cmd=1 is stored and forwarded unchanged.
- Pop qualifies when `mem_req_rd_en`=1 and `count`≠0.
- Push accepted when `count`<DEPTH, or when `count`=DEPTH and a pop qualifies in the same cycle.
- Push rejected when full with no pop in the same cycle. The entry is dropped, `mem_req_wr_overflow` sets, and it stays set until `rst`.
- Simultaneous push and pop:
  - `count` is unchanged and both pointers advance.
  - When empty, the pop is ignored and the push is stored (`count` becomes 1).
- Outputs:
  - `mem_req_rd_valid` = (`count`≠0).
  - Head fields = array[`rd_ptr`], ANDed with `mem_req_rd_valid`.
  - `mem_req_wr_almost_full` = (DEPTH−`count` ≤ AF_MARGIN), derived combinationally from `count`.
  - `mem_req_level` = `count`.
- Reset (asynchronous, any time including mid-transfer):
  - Pointers, `count` and the overflow flag clear.
  - All outputs go to 0.
  - Queued entries are lost. A pending `mem_req_rd_en` in the reset cycle has no effect.

## Timing
- Push to visible head: 1 cycle. A push on edge N gives `mem_req_rd_valid`=1 with its fields valid after edge N, when the queue was empty before N.
- A pop on edge N exposes the next entry (or `mem_req_rd_valid`=0) after edge N. Back-to-back pops sustain one entry per cycle.
- `mem_req_wr_almost_full` and `mem_req_level` update on the edge that changes `count`, with no extra latency.
- The core must stop pushing within AF_MARGIN cycles of almost_full rising. Pushes beyond that are dropped and flagged as overflow.
- Head fields are stable while `mem_req_rd_valid`=1 and no pop occurs, so `mem_shim` may hold the head across DDR3 waitrequest stalls.

## Structure
- Shared package `mem_pkg`, used by both this block and `mem_shim`:
  - `CMD_NOOP`=2'd0, `CMD_RSVD`=2'd1, `CMD_READ`=2'd2, `CMD_WRITE`=2'd3.
  - `MEM_ADDR_W`=22, `MEM_DATA_W`=64.
  - Packed struct typedef `mem_req_t` {cmd, addr, dta}.
- One sub-module, `mem_req_ram`: a simple dual-port array with synchronous write and asynchronous read, parameterised by depth and width. Pointer, count and flag logic stay in the top.

## Test plan
- Reset, then push READ addr 22'h1BCDEF → next cycle: `mem_req_rd_valid`=1, cmd=2, addr=22'h1BCDEF, level=1. Pop → valid=0, all head fields 0.
- Push WRITE addr 22'h123456 dta 64'hDEADBEEFCAFEBABE, then push cmd=0 → level stays 1, no overflow, head shows the WRITE.
- Push 12 entries with DEPTH=16, AF_MARGIN=4 → almost_full=1 exactly on the edge where level reaches 12. Push 4 more → level 16. 17th push → overflow=1, entry dropped. Pop 16 → data returned in order with no corruption.
- When full, push and pop in the same cycle → level stays 16, new entry appears last. When empty, push and pop in the same cycle → level=1, the pushed entry is at the head.
- Hold `mem_req_rd_en`=0 for 10 cycles with valid=1 → head fields unchanged. Then 20 back-to-back push/pop cycles crossing pointer wrap → output order matches input order.
- Assert `rst` asynchronously mid-cycle with level=5 and overflow=1 → all outputs 0 immediately, before the next edge. Resume pushing after release → normal operation.
